uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmitter (tx_start/tx_data/tx_busy/tx_done handshake) among NREQ byte requesters.
//  Uses round-robin arbitration and an inter-frame gap, and owns the baud divisor register (div) driven to the UART TX/RX pair.
//  Sits between the application masters and the UART core.
//  Divisor updates are applied only while the link is quiet.
// PARAMETERS
//  NREQ        4       number of requesters (2..8)
//  DIV_RST     8'd10   divisor value loaded on reset
//  GAP_CYCLES  2       idle clocks inserted after each frame (0 = none)
//  TIMEOUT     4096    max clocks from tx_start to tx_done before abort
// PORTS
//  clk        in   1        single clock, all logic rising-edge
//  rst        in   1        synchronous, active-high reset
//  req        in   NREQ     level request per requester; held until ack
//  req_data   in   8*NREQ   byte for requester i at [8i+7:8i]; stable while req[i]
//  ack        out  NREQ     one-hot 1-cycle pulse: byte of requester i captured
//  done       out  NREQ     one-hot 1-cycle pulse: requester i frame completed
//  err        out  1        1-cycle pulse: TIMEOUT expired on current frame
//  owner      out  $clog2(NREQ)  index of requester currently served
//  busy       out  1        high in any state except IDLE
//  div_wr     in   1        divisor write strobe
//  div_wdata  in   8        divisor write value
//  div        out  8        active baud divisor to UART TX/RX
//  tx_start   out  1        1-cycle start pulse to UART TX
//  tx_data    out  8        byte to UART TX, stable from tx_start until tx_done
//  tx_busy    in   1        UART TX frame in progress
//  tx_done    in   1        UART TX 1-cycle frame-complete pulse
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, done=0, err=0, tx_start=0, tx_data=0, owner=0, busy=0, div=DIV_RST, last=NREQ-1, div_pend=0.
//  FSM states: IDLE, START, WAIT, GAP.
//   IDLE: if |req, grant first set bit searching last+1, last+2 ... (mod NREQ).
//    Next cycle: ack[g]=1, owner=g, tx_data=req_data[g] latched, state=START.
//   START: when tx_busy=0, tx_start=1 for exactly one cycle, timer cleared, state=WAIT; else hold in START.
//   WAIT: on tx_done, done[owner]=1, last=owner, state=GAP (GAP_CYCLES>0) or IDLE.
//    If timer reaches TIMEOUT-1 without tx_done: err=1, last=owner, no done, same exit.
//   GAP: count GAP_CYCLES clocks, then IDLE; requests are not sampled during GAP.
//  Latency: req[i] seen in IDLE at cycle T -> ack[i] at T+1 -> tx_start at T+2 (if tx_busy=0).
//  Fairness: with all req held high, grants rotate 0,1,2,...,NREQ-1,0.
//   No requester waits more than NREQ-1 frames.
//  req dropped before ack: ignored if it falls before the IDLE sampling edge; once granted, the byte is sent regardless.
//  tx_done in any state other than WAIT: ignored.
//  Divisor: div_wr with div_wdata<2 is ignored.
//   Otherwise the value is stored in div_pend (last write wins).
//   It is applied to div on the first cycle with state=IDLE and tx_busy=0, including the same cycle as the write.
//   div never changes between tx_start and tx_done.
//   An arbitration decision in the same IDLE cycle as the div apply uses the new div.
//  rst mid-frame: FSM returns to IDLE and div=DIV_RST next cycle; in-flight byte is abandoned, no done/err.
//  ack, done and err are one-hot or zero; never more than one of ack/done high in a cycle.
//  busy = (state != IDLE).
// TESTING
//  Single req: req=4'b0100, data2=8'hA5 -> ack=4'b0100 at T+1, tx_start at T+2 with tx_data=8'hA5; tx_done -> done=4'b0100, busy low after 2 gap clocks.
//  Round-robin: req=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0; each tx_start separated by frame time + GAP_CYCLES.
//  Simultaneous new req: last=1, req=4'b1001 -> grant 3 then 0.
//  Divisor: div_wr=1, div_wdata=8'd20 during WAIT -> div stays 10 until IDLE, then 20.
//   div_wdata=8'd1 -> div unchanged.
//  Timeout: TIMEOUT=64, withhold tx_done -> err pulse at 64 clocks after tx_start, no done, next requester served.
//  Reset mid-frame: assert rst for 1 cycle in WAIT -> all outputs at reset values next cycle; a late tx_done produces no done.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin sharing of one UART transmitter among NREQ byte
//            requesters, with inter-frame gap, frame timeout and a baud
//            divisor register that only changes while the link is quiet.
// Revision : 1.0
// ============================================================================
module uart_tx_scheduler #(
    parameter int         NREQ       = 4,
    parameter logic [7:0] DIV_RST    = 8'd10,
    parameter int         GAP_CYCLES = 2,
    parameter int         TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    input  logic                    div_wr,
    input  logic [7:0]              div_wdata,
    output logic [7:0]              div,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done
);

    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_GAP   = 2'd3;

    localparam logic [TW-1:0]   c_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   c_GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [NREQ-1:0] c_ONE      = NREQ'(1);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [OW-1:0]   r_last;
    logic [OW-1:0]   r_owner;
    logic [TW-1:0]   r_timer;
    logic [GW-1:0]   r_gap_cnt;
    logic [NREQ-1:0] r_ack;
    logic [NREQ-1:0] r_done;
    logic            r_err;
    logic            r_tx_start;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_div;
    logic [7:0]      r_div_pend;
    logic            r_pend_vld;

    logic            w_grant_vld;
    logic [OW-1:0]   w_grant_idx;
    logic [OW-1:0]   w_scan_idx;
    logic [7:0]      w_grant_data;
    logic            w_tmo;
    logic            w_gap_end;
    logic            w_div_ok;
    logic            w_div_apply;

    // Rotating priority: the search starts just after the last served requester.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan_idx = OW'((int'(r_last) + k) % NREQ);
            if (!w_grant_vld && req[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_grant_data = req_data[{w_grant_idx, 3'b000} +: 8];
    assign w_tmo        = (r_timer == c_TMO_LAST);
    assign w_gap_end    = (r_gap_cnt == c_GAP_LAST);
    assign w_div_ok     = div_wr && (div_wdata >= 8'd2);
    assign w_div_apply  = (r_state == c_IDLE) && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_grant_vld) w_next_state = c_START;
            c_START: if (!tx_busy) w_next_state = c_WAIT;
            c_WAIT:  if (tx_done || w_tmo) w_next_state = (GAP_CYCLES > 0) ? c_GAP : c_IDLE;
            c_GAP:   if (w_gap_end) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= OW'(NREQ - 1);
            r_owner    <= '0;
            r_timer    <= '0;
            r_gap_cnt  <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_div      <= DIV_RST;
            r_div_pend <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_tx_start <= 1'b0;
            r_gap_cnt  <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_vld) begin
                        r_ack     <= c_ONE << w_grant_idx;
                        r_owner   <= w_grant_idx;
                        r_tx_data <= w_grant_data;
                    end
                end
                c_START: begin
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_timer    <= '0;
                    end
                end
                c_WAIT: begin
                    if (tx_done) begin
                        r_done <= c_ONE << r_owner;
                        r_last <= r_owner;
                    end else if (w_tmo) begin
                        r_err  <= 1'b1;
                        r_last <= r_owner;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                c_GAP: begin
                    r_gap_cnt <= r_gap_cnt + GW'(1);
                end
                default: ;
            endcase

            // A write arriving in a quiet cycle bypasses the pending slot.
            if (w_div_ok) begin
                r_div_pend <= div_wdata;
                r_pend_vld <= 1'b1;
            end
            if (w_div_apply) begin
                if (w_div_ok) begin
                    r_div <= div_wdata;
                end else if (r_pend_vld) begin
                    r_div <= r_div_pend;
                end
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign ack      = r_ack;
    assign done     = r_done;
    assign err      = r_err;
    assign owner    = r_owner;
    assign div      = r_div;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

endmodule

`default_nettype wire
